// File: rtl/edge_grad_pkg.sv
// ============================================================================
// edge_grad_pkg : shared output-mode encodings for the edge_grad detector
// Revision 1.0
// ============================================================================
`default_nettype none

package edge_grad_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_MEAN = 2'd0;
  localparam mode_t MODE_MAX  = 2'd1;
  localparam mode_t MODE_BIN  = 2'd2;
  localparam mode_t MODE_SAT  = 2'd3;
endpackage

`default_nettype wire

// File: rtl/edge_grad_if.sv
// ============================================================================
// edge_grad_if : pixel stream in/out bundle for the edge_grad detector
// Revision 1.0
// ============================================================================
`default_nettype none

interface edge_grad_if
  import edge_grad_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int COL_W = 8
) ();
  logic [PIX_W-1:0] PixelIn;
  logic             ValidIn;
  logic             FrameIn;
  logic             LineIn;
  logic [COL_W-1:0] Width;
  mode_t            Mode;
  logic [PIX_W:0]   Threshold;
  logic [PIX_W-1:0] PixelOut;
  logic             ValidOut;
  logic             FrameOut;
  logic             LineOut;

  modport master (
    output PixelIn, ValidIn, FrameIn, LineIn, Width, Mode, Threshold,
    input  PixelOut, ValidOut, FrameOut, LineOut
  );

  modport slave (
    input  PixelIn, ValidIn, FrameIn, LineIn, Width, Mode, Threshold,
    output PixelOut, ValidOut, FrameOut, LineOut
  );
endinterface

`default_nettype wire

// File: rtl/edge_line_buf.sv
// ============================================================================
// edge_line_buf : single-port synchronous RAM, read-before-write
// Revision 1.0
// ============================================================================
`default_nettype none

module edge_line_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  wire logic             clk,
  input  wire logic [AW-1:0]    i_addr,
  input  wire logic             i_we,
  input  wire logic [WIDTH-1:0] i_wdata,
  output logic      [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Old contents are read out in the same cycle the new pixel overwrites them.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_addr];
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_rdata;
endmodule

`default_nettype wire

// File: rtl/edge_grad.sv
// ============================================================================
// edge_grad : streaming |dx|+|dy| edge detector, 3-cycle fixed latency
// Revision 1.0
// ============================================================================
`default_nettype none

module edge_grad
  import edge_grad_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int MAX_W = 256,
  parameter int COL_W = 8
) (
  input wire logic  Clk,
  input wire logic  nReset,
  edge_grad_if.slave bus
);
  localparam int CW = COL_W + 1;
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CW-1:0]    C_MAX_COL = CW'(MAX_W);
  localparam logic [PIX_W-1:0] C_ONES    = '1;

  logic [CW-1:0]    w_width_in, w_width, w_col;
  logic             w_inline;
  logic             r1_valid, r1_frame, r1_line;
  logic [PIX_W-1:0] r_pix;
  logic [CW-1:0]    r_col, r_width;
  logic             r_inline, r_first, r_synced;
  mode_t            r_mode;
  logic [PIX_W:0]   r_thr;

  always_comb begin
    w_width_in = ((bus.Width == '0) || ({1'b0, bus.Width} > C_MAX_COL)) ? C_MAX_COL : {1'b0, bus.Width};
    w_width    = bus.FrameIn ? w_width_in : r_width;
    w_col      = (bus.FrameIn || bus.LineIn) ? '0 :
                 ((r_col >= C_MAX_COL) ? C_MAX_COL : r_col + 1'b1);
    w_inline   = (w_col < w_width);
  end

  // Stage 1: column/row tracking; state only moves on qualified pixels.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r1_valid <= 1'b0;
      r1_frame <= 1'b0;
      r1_line  <= 1'b0;
      r_pix    <= '0;
      r_col    <= '0;
      r_inline <= 1'b0;
      r_first  <= 1'b1;
      r_synced <= 1'b0;
      r_width  <= C_MAX_COL;
      r_mode   <= MODE_MEAN;
      r_thr    <= '0;
    end else begin
      r1_valid <= bus.ValidIn;
      r1_frame <= bus.ValidIn & bus.FrameIn;
      r1_line  <= bus.ValidIn & (bus.FrameIn | bus.LineIn);
      if (bus.ValidIn) begin
        r_pix    <= bus.PixelIn;
        r_col    <= w_col;
        r_inline <= w_inline;
        if (bus.FrameIn) begin
          r_first  <= 1'b1;
          r_synced <= 1'b1;
          r_width  <= w_width_in;
          r_mode   <= bus.Mode;
          r_thr    <= bus.Threshold;
        end else if (bus.LineIn) begin
          r_first  <= 1'b0;
        end
      end
    end
  end

  logic [PIX_W-1:0] w_above;

  edge_line_buf #(.DEPTH(MAX_W), .WIDTH(PIX_W), .AW(AW)) u_line_buf (
    .clk    (Clk),
    .i_addr (r_col[AW-1:0]),
    .i_we   (r1_valid & r_inline),
    .i_wdata(r_pix),
    .o_rdata(w_above)
  );

  logic             r2_valid, r2_frame, r2_line, r2_col0, r2_first, r2_live;
  logic [PIX_W-1:0] r_left, r2_pix, r2_left;
  mode_t            r2_mode;
  logic [PIX_W:0]   r2_thr;

  // Stage 2: aligns with the buffer read; left neighbour advances on in-line pixels only.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_left   <= '0;
      r2_valid <= 1'b0;
      r2_frame <= 1'b0;
      r2_line  <= 1'b0;
      r2_col0  <= 1'b0;
      r2_first <= 1'b1;
      r2_live  <= 1'b0;
      r2_pix   <= '0;
      r2_left  <= '0;
      r2_mode  <= MODE_MEAN;
      r2_thr   <= '0;
    end else begin
      if (r1_valid && r_inline) r_left <= r_pix;
      r2_valid <= r1_valid;
      r2_frame <= r1_frame;
      r2_line  <= r1_line;
      r2_col0  <= (r_col == '0);
      r2_first <= r_first;
      r2_live  <= r_synced & r_inline;
      r2_pix   <= r_pix;
      r2_left  <= r_left;
      r2_mode  <= r_mode;
      r2_thr   <= r_thr;
    end
  end

  logic [PIX_W-1:0] w_dx, w_dy, w_res;
  logic [PIX_W:0]   w_sum;

  always_comb begin
    w_dx  = r2_col0  ? '0 : ((r2_pix > r2_left) ? r2_pix - r2_left : r2_left - r2_pix);
    w_dy  = r2_first ? '0 : ((r2_pix > w_above) ? r2_pix - w_above : w_above - r2_pix);
    w_sum = {1'b0, w_dx} + {1'b0, w_dy};
    w_res = '0;
    case (r2_mode)
      MODE_MEAN: w_res = w_sum[PIX_W:1];
      MODE_MAX:  w_res = (w_dx >= w_dy) ? w_dx : w_dy;
      MODE_BIN:  w_res = (w_sum >= r2_thr) ? C_ONES : '0;
      MODE_SAT:  w_res = w_sum[PIX_W] ? C_ONES : w_sum[PIX_W-1:0];
      default:   w_res = '0;
    endcase
  end

  logic [PIX_W-1:0] r_pix_out;
  logic             r_valid_out, r_frame_out, r_line_out;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_pix_out   <= '0;
      r_valid_out <= 1'b0;
      r_frame_out <= 1'b0;
      r_line_out  <= 1'b0;
    end else begin
      r_pix_out   <= (r2_valid && r2_live) ? w_res : '0;
      r_valid_out <= r2_valid;
      r_frame_out <= r2_frame;
      r_line_out  <= r2_line;
    end
  end

  assign bus.PixelOut = r_pix_out;
  assign bus.ValidOut = r_valid_out;
  assign bus.FrameOut = r_frame_out;
  assign bus.LineOut  = r_line_out;
endmodule

`default_nettype wire

// File: doc/edge_grad.md
# edge_grad

Parametrised streaming gradient-magnitude edge detector; successor to the fixed 8-bit, fixed-buffer edge stage in the pixel pipeline. Computes |left difference| + |above difference| per pixel from a single on-chip line buffer, with valid-qualified input (gaps allowed), explicit image-border handling, frame-latched width/mode, and four output modes including thresholded binary. Sits between the pixel source (camera/frame reader) and the Hough accumulator front end.

## Interface
- PIX_W, 8, pixel bit width (≥2)
- MAX_W, 256, line buffer depth = maximum supported line width
- COL_W, 8, column counter / Width port width; 2^COL_W ≥ MAX_W
- Clk  in  1  rising-edge clock
- nReset  in  1  asynchronous, active-low reset
- PixelIn  in  PIX_W  input pixel, unsigned
- ValidIn  in  1  PixelIn/FrameIn/LineIn qualified this cycle
- FrameIn  in  1  with ValidIn: this pixel is first of a frame (also starts a line)
- LineIn  in  1  with ValidIn: this pixel is first of a line
- Width  in  COL_W  active pixels per line; latched on FrameIn
- Mode  in  2  output mode; latched on FrameIn
- Threshold  in  PIX_W+1  binary-mode threshold; latched on FrameIn
- PixelOut  out  PIX_W  edge magnitude
- ValidOut  out  1  PixelOut/FrameOut/LineOut qualified
- FrameOut  out  1  FrameIn delayed with its pixel
- LineOut  out  1  LineIn (or FrameIn) delayed with its pixel

## Operation
- Column counter col: on valid pixel with FrameIn or LineIn, col=0 for that pixel; else col+1 per valid pixel, saturating at MAX_W.
- Row state: first_row set by valid FrameIn, cleared by next valid LineIn without FrameIn. synced flag cleared by reset, set by first valid FrameIn.
- Width latch: 0 or >MAX_W treated as MAX_W. Pixels with col ≥ Width are out-of-line: not written to buffer, output PixelOut=0 (ValidOut still asserted).
- Line buffer: MAX_W × PIX_W, read-before-write at address col; read returns pixel above. Written only by in-line valid pixels.
- Left neighbour: register holding previous in-line valid pixel.
- dx = |p − left| (0 if col==0); dy = |p − above| (0 if first_row). Both PIX_W bits; sum = dx+dy, PIX_W+1 bits, no overflow.
- Mode 0: sum>>1. Mode 1: max(dx,dy). Mode 2: all-ones if sum ≥ Threshold else 0. Mode 3: sum saturated to 2^PIX_W−1.
- Before synced: PixelOut=0, FrameOut/LineOut pass through, ValidOut follows ValidIn.
- ValidIn=0 cycles: no state change in col, buffer, left register; pipeline advances with ValidOut=0.
- FrameIn mid-line: abandons current line; col=0, first_row=1, new Width/Mode/Threshold apply from that pixel.

## Timing
- Fixed latency 3 cycles: ValidIn/PixelIn at cycle t → ValidOut/PixelOut at t+3; FrameOut/LineOut aligned to same pixel.
- Stage 1: input register + col/row update. Stage 2: buffer read, dx/dy. Stage 3: mode combine into output register.
- Reset (async, any time): PixelOut=0, ValidOut=0, FrameOut=0, LineOut=0, col=0, first_row=1, synced=0, latched Width=MAX_W, Mode=0, Threshold=0; in-flight pixels discarded. Buffer contents not reset (masked by first_row).
- Throughput one pixel per cycle; no backpressure.

## Structure
- Shared package: mode encodings (MODE_MEAN=0, MODE_MAX=1, MODE_BIN=2, MODE_SAT=3).
- Sub-module edge_line_buf: single-port synchronous read-before-write RAM, parametrised by depth/width.

## Test plan
- PIX_W=8, Width=4, Mode 0, 2×4 frame rows {10,20,30,40},{10,20,30,40} → row0: 0,5,5,5; row1: 0,5,5,5; latency exactly 3.
- Mode 2, Threshold=20, row1 pixel 100 above 60, left 95 → sum=45 → 255; pixel 62 above 60, left 62 → 0.
- ValidIn gaps of 1–3 cycles inside a line → identical PixelOut sequence to gap-free run, ValidOut low in gap slots.
- Width=3, four pixels per line → fourth pixel output 0, next row's col 2 uses correct above value.
- Mode 3, pixels 255 after 0 left and 0 above → 255 (saturated); Mode 1 → 255.
- nReset pulse mid-line → all outputs 0 next cycle; outputs 0 until first FrameIn, then border rules restart.
